// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and default widths for the instruction-fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int INSTR_W_DEF = 9;
    localparam int PC_W_DEF    = 9;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Circular prefetch buffer of {instr, pc} entries with sync flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    empty,
    output logic                    full
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_L);
    assign level   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : PC sequencer, 1-cycle imem request port and prefetch queue.
//            Define FETCH_BYPASS_EN to forward responses straight to an empty head.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [PC_W-1:0]         start_addr,
    input  logic                    halt,
    input  logic                    branch,
    input  logic [PC_W-1:0]         target,
    output logic                    imem_req,
    output logic [PC_W-1:0]         imem_addr,
    input  logic [INSTR_W-1:0]      imem_rdata,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [INSTR_W-1:0]      instr_out,
    output logic [PC_W-1:0]         instr_pc,
    output logic [$clog2(DEPTH):0]  level,
    output logic [COUNT_W-1:0]      instr_count,
    output logic                    running
);

    localparam int                 LVL_W     = $clog2(DEPTH) + 1;
    localparam int                 ENT_W     = INSTR_W + PC_W;
    localparam logic [LVL_W:0]     DEPTH_C   = (LVL_W+1)'(DEPTH);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    fetch_state_t        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                imem_req_q, imem_req_d;
    logic [PC_W-1:0]     imem_addr_q, imem_addr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [PC_W-1:0]     rsp_pc_q, rsp_pc_d;
    logic                kill_q, kill_d;
    logic [COUNT_W-1:0]  count_q, count_d;

    logic                run, redirect, rsp_ok, bypass, deq;
    logic                fifo_wr, fifo_rd, fifo_empty, fifo_full, credit_ok;
    logic [LVL_W-1:0]    fifo_level;
    logic [ENT_W-1:0]    head;
    logic [LVL_W:0]      used;

    assign run      = (state_q == RUN);
    assign redirect = start | (run & branch);
    // kill_q covers a redirect in the issue cycle, redirect covers the return cycle
    assign rsp_ok   = rsp_valid_q & ~kill_q & ~redirect;

    assign used = (LVL_W+1)'(fifo_level) + (LVL_W+1)'(imem_req_q)
                + (LVL_W+1)'(rsp_valid_q & ~kill_q);
    assign credit_ok = (used < DEPTH_C) & ~fifo_full;

`ifdef FETCH_BYPASS_EN
    assign bypass = run & fifo_empty & rsp_ok & instr_ready;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = (run & ~fifo_empty) | bypass;
    assign instr_out   = bypass ? imem_rdata : head[ENT_W-1:PC_W];
    assign instr_pc    = bypass ? rsp_pc_q   : head[PC_W-1:0];
    assign deq         = instr_valid & instr_ready;
    assign fifo_wr     = rsp_ok & ~bypass;
    assign fifo_rd     = deq & ~bypass;

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign level       = fifo_level;
    assign instr_count = count_q;
    assign running     = run;

    fetch_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect),
        .wr_en   (fifo_wr),
        .wr_data ({imem_rdata, rsp_pc_q}),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .level   (fifo_level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Redirects put the new address on the bus the very next cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        count_d     = count_q;
        rsp_valid_d = imem_req_q;
        rsp_pc_d    = imem_addr_q;
        kill_d      = redirect;
        if (start) begin
            state_d     = RUN;
            imem_req_d  = 1'b1;
            imem_addr_d = start_addr;
            pc_d        = start_addr + PC_W'(1);
            count_d     = '0;
        end else if (run) begin
            if (deq && (count_q != COUNT_MAX)) begin
                count_d = count_q + COUNT_W'(1);
            end
            if (branch) begin
                imem_req_d  = 1'b1;
                imem_addr_d = target;
                pc_d        = target + PC_W'(1);
            end else if (halt) begin
                state_d = HALTED;
            end else if (credit_ok) begin
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q;
                pc_d        = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= '0;
            kill_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
            kill_q      <= kill_d;
            count_q     <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed self-checking bench for fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int INSTR_W = 9;
    localparam int PC_W    = 9;
    localparam int DEPTH   = 4;
    localparam int COUNT_W = 3;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic               halt;
    logic               branch;
    logic [PC_W-1:0]    target;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    instr_pc;
    logic [LVL_W-1:0]   level;
    logic [COUNT_W-1:0] instr_count;
    logic               running;

    int                 checks = 0;
    int                 errors = 0;
    logic               prev_req;
    logic [PC_W-1:0]    prev_addr;

    fetch_queue #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W),
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .halt        (halt),
        .branch      (branch),
        .target      (target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .level       (level),
        .instr_count (instr_count),
        .running     (running)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] imem_model(input logic [PC_W-1:0] a);
        return a ^ 9'h155;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; then answer last cycle's request, as instruction memory would.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_rdata = prev_req ? imem_model(prev_addr) : '0;
        prev_req   = imem_req;
        prev_addr  = imem_addr;
    endtask

    initial begin
        int reqs;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; halt = 1'b0;
        branch = 1'b0; target = '0; instr_ready = 1'b0; imem_rdata = '0;
        prev_req = 1'b0; prev_addr = '0;

        repeat (3) tick();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_out", instr_out, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_level", level, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_running", running, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_req", imem_req, 0);
        chk("idle_running", running, 0);

        // Start at 0x010 with the decoder always ready.
        start = 1'b1; start_addr = 9'h010; instr_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("t1_req", imem_req, 1);
            chk("t1_addr", imem_addr, 9'h010 + k - 1);
            chk("t1_running", running, 1);
            chk("t1_valid", instr_valid, (k > LAT) ? 1 : 0);
            if (k > LAT) begin
                chk("t1_pc", instr_pc, 9'h010 + k - 1 - LAT);
                chk("t1_out", instr_out, imem_model(PC_W'(9'h010 + k - 1 - LAT)));
                chk("t1_count", instr_count, k - 1 - LAT);
            end
            tick();
        end

        // Backpressure: exactly DEPTH requests, then no more.
        start = 1'b1; start_addr = 9'h010; instr_ready = 1'b0;
        tick();
        start = 1'b0;
        reqs = 0;
        for (int k = 1; k <= 8; k++) begin
            if (imem_req) begin
                chk("t2_addr", imem_addr, 9'h010 + reqs);
                reqs++;
            end
            if (k < 8) tick();
        end
        chk("t2_reqs", reqs, 4);
        chk("t2_level", level, 4);
        chk("t2_req_off", imem_req, 0);
        chk("t2_valid", instr_valid, 1);
        chk("t2_pc0", instr_pc, 9'h010);
        chk("t2_count0", instr_count, 0);
        instr_ready = 1'b1;
        tick();
        chk("t2_nocredit", imem_req, 0);
        chk("t2_pc1", instr_pc, 9'h011);
        chk("t2_level1", level, 3);
        tick();
        chk("t2_req_resume", imem_req, 1);
        chk("t2_addr_resume", imem_addr, 9'h014);
        chk("t2_pc2", instr_pc, 9'h012);
        tick();
        chk("t2_pc3", instr_pc, 9'h013);
        tick();
        chk("t2_pc4", instr_pc, 9'h014);
        chk("t2_count4", instr_count, 4);

        // Branch while responses are in flight.
        repeat (3) tick();
        branch = 1'b1; target = 9'h100;
        tick();
        branch = 1'b0;
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 9'h100);
        chk("t3_flush_level", level, 0);
        chk("t3_flush_valid", instr_valid, 0);
        tick();
        chk("t3_stale_level", level, 0);
        chk("t3_valid_n2", instr_valid, (LAT == 1) ? 1 : 0);
        repeat (LAT - 1) tick();
        chk("t3_valid", instr_valid, 1);
        chk("t3_pc", instr_pc, 9'h100);
        chk("t3_out", instr_out, imem_model(9'h100));

        // PC wrap from the top of the address space.
        start = 1'b1; start_addr = 9'h1FE;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("t4_req", imem_req, 1);
            chk("t4_addr", imem_addr, (9'h1FE + k - 1) & 9'h1FF);
            if (k > LAT) begin
                chk("t4_pc", instr_pc, (9'h1FE + k - 1 - LAT) & 9'h1FF);
                chk("t4_count", instr_count, k - 1 - LAT);
            end
            if (k < 6) tick();
        end

        // Halt mid-stream, ignored branch while halted, then restart.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t5_running", running, 0);
        chk("t5_valid", instr_valid, 0);
        chk("t5_req", imem_req, 0);
        chk("t5_count", instr_count, 6 - LAT);
        tick();
        chk("t5_hold_level", level, LAT);
        chk("t5_hold_count", instr_count, 6 - LAT);
        branch = 1'b1; target = 9'h0AA;
        tick();
        branch = 1'b0;
        chk("t5_br_req", imem_req, 0);
        chk("t5_br_running", running, 0);
        chk("t5_br_level", level, LAT);
        chk("t5_br_valid", instr_valid, 0);

        start = 1'b1; start_addr = 9'h020;
        tick();
        start = 1'b0;
        chk("t6_count", instr_count, 0);
        chk("t6_running", running, 1);
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, 9'h020);
        chk("t6_level", level, 0);
        chk("t6_valid0", instr_valid, 0);
        repeat (LAT) tick();
        chk("t6_valid", instr_valid, 1);
        chk("t6_pc", instr_pc, 9'h020);
        chk("t6_count0", instr_count, 0);
        repeat (11 - LAT) tick();
        chk("t6_sat", instr_count, 7);
        tick();
        chk("t6_sat_hold", instr_count, 7);
        chk("t6_stream", instr_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
